// File: rtl/core_pkg.sv
// Shared definitions for the ARMv4 core front end.
// Contents:
//   WORD_W        - datapath / address width
//   PC_STEP       - sequential fetch increment
//   PC_R15_OFFSET - pipeline offset seen when R15 is read
//   fetch_state_t - fetch_stage FSM encoding
//   imem_req_t    - registered request presented to instruction memory
//   word_align()  - clears the byte-offset bits of an address
package core_pkg;

    localparam int WORD_W        = 32;
    localparam int PC_STEP       = 4;
    localparam int PC_R15_OFFSET = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        DISCARD = 3'd3,
        ERR     = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic              req;
        logic [WORD_W-1:0] addr;
    } imem_req_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait-state counter for the instruction fetch handshake.
// Ports:
//   clk, rst - core clock, asynchronous active-low reset
//   clr      - return the count to zero (has priority over inc)
//   inc      - one more cycle spent waiting for an ack
//   term     - the count has reached LIMIT-1, i.e. this is the LIMIT-th
//              waiting cycle if inc is also high
module fetch_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam int CW = 8;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and holds one instruction until the decoder takes it.
// Ports:
//   clk, rst      - core clock, asynchronous active-low reset
//   imem_req      - fetch request, held until imem_ack
//   imem_addr     - word-aligned fetch address, stable while waiting
//   imem_rdata    - instruction word, qualified by imem_ack
//   imem_ack      - one-cycle completion strobe
//   instr         - held instruction
//   instr_valid   - instr is valid and not yet consumed
//   instr_ready   - consumer retires the held instruction this cycle
//   pc_src        - take result as next PC (sampled on consume only)
//   result        - redirect / flush target
//   flush         - abort the outstanding fetch and restart at result
//   pc            - address of the held instruction
//   pc_plus8      - pc + 8, the R15 read value
//   bus_err       - sticky: ack timeout or misaligned redirect
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_src,
    input  logic [31:0] result,
    input  logic        flush,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        bus_err
);

    fetch_state_t      state;
    imem_req_t         mreq;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] instr_q;
    logic              valid_q;
    logic              err_q;

    logic [WORD_W-1:0] tgt;
    logic              misal;
    logic [WORD_W-1:0] next_pc;
    logic              waiting;
    logic              term;

    assign tgt     = word_align(result);
    assign misal   = |result[1:0];
    assign next_pc = pc_src ? tgt : pc_q + WORD_W'(PC_STEP);

    // Counting covers DISCARD too: the dropped transaction can hang the bus
    // just as well as a live one.
    assign waiting = ((state == REQ) || (state == DISCARD)) && !imem_ack;

    fetch_timeout_ctr #(
        .LIMIT (ACK_TIMEOUT)
    ) u_tmo (
        .clk  (clk),
        .rst  (rst),
        .clr  (!waiting),
        .inc  (waiting),
        .term (term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mreq.req  <= 1'b0;
            mreq.addr <= RESET_PC;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mreq.req  <= 1'b1;
                    mreq.addr <= pc_q;
                    state     <= REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (flush) begin
                            // Data belongs to the aborted stream; the bus is
                            // free, so the new request can go out at once.
                            pc_q      <= tgt;
                            mreq.addr <= tgt;
                            err_q     <= err_q | misal;
                        end else begin
                            instr_q  <= imem_rdata;
                            valid_q  <= 1'b1;
                            mreq.req <= 1'b0;
                            state    <= HOLD;
                        end
                    end else if (term) begin
                        err_q    <= 1'b1;
                        mreq.req <= 1'b0;
                        state    <= ERR;
                    end else if (flush) begin
                        // Address must not move until the pending ack lands.
                        pc_q  <= tgt;
                        err_q <= err_q | misal;
                        state <= DISCARD;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        valid_q   <= 1'b0;
                        pc_q      <= tgt;
                        mreq.req  <= 1'b1;
                        mreq.addr <= tgt;
                        err_q     <= err_q | misal;
                        state     <= REQ;
                    end else if (instr_ready) begin
                        valid_q   <= 1'b0;
                        pc_q      <= next_pc;
                        mreq.req  <= 1'b1;
                        mreq.addr <= next_pc;
                        err_q     <= err_q | (pc_src & misal);
                        state     <= REQ;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        // One idle cycle separates the dropped and new requests.
                        mreq.req <= 1'b0;
                        state    <= IDLE;
                    end else if (term) begin
                        err_q    <= 1'b1;
                        mreq.req <= 1'b0;
                        state    <= ERR;
                    end else if (flush) begin
                        pc_q  <= tgt;
                        err_q <= err_q | misal;
                    end
                end
                ERR: begin
                    mreq.req <= 1'b0;
                    valid_q  <= 1'b0;
                end
                default: begin
                    mreq.req <= 1'b0;
                    valid_q  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = mreq.req;
    assign imem_addr   = mreq.addr;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus8    = pc_q + WORD_W'(PC_R15_OFFSET);
    assign bus_err     = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [31:0] result;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        bus_err;

    // Table-phase drives ack/rdata directly; later sequences use the memory model.
    logic        mem_en;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    int          mem_wait;
    int          mem_acks;
    int          mcnt;
    logic        tbl_ack;
    logic [31:0] tbl_rdata;

    int checks;
    int fails;

    assign imem_ack   = mem_en ? mem_ack   : tbl_ack;
    assign imem_rdata = mem_en ? mem_rdata : tbl_rdata;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_src      (pc_src),
        .result      (result),
        .flush       (flush),
        .pc          (pc),
        .pc_plus8    (pc_plus8),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks in the (mem_wait+1)-th cycle of a request, data = ~addr.
    initial begin
        mem_ack = 1'b0; mem_rdata = '0; mcnt = 0; mem_acks = 0;
    end
    always begin
        @(posedge clk);
        #1;
        if (!mem_en || !imem_req) begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end else if (mcnt == mem_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = ~imem_addr;
            mcnt      = 0;
            mem_acks++;
        end else begin
            mem_ack = 1'b0;
            mcnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        src;
        logic        fl;
        logic [31:0] res;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    function automatic vec_t mkv(logic a, logic [31:0] rd, logic rdy, logic s, logic f,
                                 logic [31:0] r, logic er, logic [31:0] ea, logic ev,
                                 logic [31:0] ep, logic [31:0] ei);
        vec_t v;
        v.ack = a; v.rdata = rd; v.ready = rdy; v.src = s; v.fl = f; v.res = r;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim, input string nm);
        int n;
        n = 0;
        while (!instr_valid && n < lim) begin
            step();
            n++;
        end
        checks++;
        if (!instr_valid) begin
            fails++;
            $display("FAIL %s: instr_valid not seen within %0d cycles", nm, lim);
        end
    endtask

    function automatic logic [31:0] iw(int k);
        return 32'hE000_0000 + 32'(k);
    endfunction

    initial begin
        logic [31:0] p;
        int          base;
        checks = 0; fails = 0;
        mem_en = 1'b0; mem_wait = 0;
        tbl_ack = 1'b0; tbl_rdata = '0;
        instr_ready = 1'b0; pc_src = 1'b0; result = '0; flush = 1'b0;

        //        ack rdata   rdy src fl res            req addr          vld pc            instr
        tbl[0]  = mkv(0, 0,      1, 0, 0, 0,            1, 32'h0,        0, 32'h0,        32'h0);
        tbl[1]  = mkv(1, iw(0),  1, 0, 0, 0,            0, 32'h0,        1, 32'h0,        iw(0));
        tbl[2]  = mkv(0, 0,      1, 0, 0, 0,            1, 32'h4,        0, 32'h4,        iw(0));
        tbl[3]  = mkv(1, iw(1),  1, 0, 0, 0,            0, 32'h4,        1, 32'h4,        iw(1));
        tbl[4]  = mkv(0, 0,      1, 0, 0, 0,            1, 32'h8,        0, 32'h8,        iw(1));
        tbl[5]  = mkv(1, iw(2),  1, 0, 0, 0,            0, 32'h8,        1, 32'h8,        iw(2));
        tbl[6]  = mkv(0, 0,      1, 0, 0, 0,            1, 32'hC,        0, 32'hC,        iw(2));
        tbl[7]  = mkv(1, iw(3),  1, 0, 0, 0,            0, 32'hC,        1, 32'hC,        iw(3));
        tbl[8]  = mkv(0, 0,      1, 0, 0, 0,            1, 32'h10,       0, 32'h10,       iw(3));
        tbl[9]  = mkv(1, iw(4),  1, 0, 0, 0,            0, 32'h10,       1, 32'h10,       iw(4));
        tbl[10] = mkv(0, 0,      1, 1, 0, 32'h100,      1, 32'h100,      0, 32'h100,      iw(4));
        tbl[11] = mkv(1, iw(5),  1, 0, 0, 0,            0, 32'h100,      1, 32'h100,      iw(5));
        tbl[12] = mkv(0, 0,      0, 0, 0, 0,            0, 32'h100,      1, 32'h100,      iw(5));
        tbl[13] = mkv(0, 0,      1, 0, 1, 32'h200,      1, 32'h200,      0, 32'h200,      iw(5));
        tbl[14] = mkv(1, iw(6),  1, 0, 0, 0,            0, 32'h200,      1, 32'h200,      iw(6));
        tbl[15] = mkv(0, 0,      1, 1, 0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, iw(6));
        tbl[16] = mkv(1, iw(7),  1, 0, 0, 0,            0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, iw(7));
        tbl[17] = mkv(0, 0,      1, 0, 0, 0,            1, 32'h0,        0, 32'h0,        iw(7));
        tbl[18] = mkv(0, 0,      1, 0, 0, 0,            1, 32'h0,        0, 32'h0,        iw(7));
        tbl[19] = mkv(1, iw(8),  1, 0, 0, 0,            0, 32'h0,        1, 32'h0,        iw(8));
        tbl[20] = mkv(0, 0,      1, 0, 0, 0,            1, 32'h4,        0, 32'h4,        iw(8));
        tbl[21] = mkv(1, iw(9),  1, 0, 1, 32'h40,       1, 32'h40,       0, 32'h40,       iw(8));
        tbl[22] = mkv(1, iw(10), 1, 0, 0, 0,            0, 32'h40,       1, 32'h40,       iw(10));

        // Reset state
        rst = 1'b0;
        #12;
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_pc",    pc,                   32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr,                32'h0);
        chk("rst_err",   {31'b0, bus_err},     32'h0);
        chk("rst_pc8",   pc_plus8,             32'h8);
        @(posedge clk); #1;
        rst = 1'b1;

        // Zero-wait streaming, redirect, flush in HOLD, wrap, flush with ack
        for (int i = 0; i < NV; i++) begin
            tbl_ack = tbl[i].ack; tbl_rdata = tbl[i].rdata;
            instr_ready = tbl[i].ready; pc_src = tbl[i].src;
            flush = tbl[i].fl; result = tbl[i].res;
            step();
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,            tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("v%0d_pc", i),    pc,                   tbl[i].e_pc);
            chk($sformatf("v%0d_pc8", i),   pc_plus8,             tbl[i].e_pc + 32'd8);
            chk($sformatf("v%0d_instr", i), instr,                tbl[i].e_instr);
            chk($sformatf("v%0d_err", i),   {31'b0, bus_err},     32'h0);
        end
        tbl_ack = 1'b0; instr_ready = 1'b0; pc_src = 1'b0; flush = 1'b0; result = '0;

        // 3 wait states, consumer stalls 5 cycles
        mem_wait = 3; mem_en = 1'b1;
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        base = mem_acks;
        chk("ws_addr", imem_addr, 32'h44);
        wait_valid(20, "ws_valid");
        chk("ws_instr", instr, ~32'h44);
        chk("ws_pc",    pc,    32'h44);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ws_hold%0d_valid", i), {31'b0, instr_valid}, 32'h1);
            chk($sformatf("ws_hold%0d_req", i),   {31'b0, imem_req},    32'h0);
            chk($sformatf("ws_hold%0d_instr", i), instr,                ~32'h44);
            chk($sformatf("ws_hold%0d_pc", i),    pc,                   32'h44);
        end
        chk("ws_one_fetch", 32'(mem_acks - base), 32'h1);

        // Flush two cycles into a pending fetch at 0x20
        instr_ready = 1'b1; pc_src = 1'b1; result = 32'h20;
        step();
        instr_ready = 1'b0; pc_src = 1'b0;
        chk("fl_addr0", imem_addr, 32'h20);
        step();
        flush = 1'b1; result = 32'h200;
        step();
        flush = 1'b0; result = '0;
        chk("fl_d1_req",   {31'b0, imem_req},    32'h1);
        chk("fl_d1_addr",  imem_addr,            32'h20);
        chk("fl_d1_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("fl_d2_req",   {31'b0, imem_req},    32'h1);
        chk("fl_d2_addr",  imem_addr,            32'h20);
        step();
        chk("fl_gap_req",   {31'b0, imem_req},    32'h0);
        chk("fl_gap_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("fl_new_req",  {31'b0, imem_req}, 32'h1);
        chk("fl_new_addr", imem_addr,         32'h200);
        chk("fl_new_valid", {31'b0, instr_valid}, 32'h0);
        wait_valid(20, "fl_valid");
        chk("fl_pc",    pc,    32'h200);
        chk("fl_instr", instr, ~32'h200);

        // Ack timeout
        mem_en = 1'b0; tbl_ack = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("to_addr", imem_addr, 32'h204);
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("to_wait%0d_err", i), {31'b0, bus_err},  32'h0);
            chk($sformatf("to_wait%0d_req", i), {31'b0, imem_req}, 32'h1);
        end
        step();
        chk("to_err", {31'b0, bus_err},  32'h1);
        chk("to_req", {31'b0, imem_req}, 32'h0);
        tbl_ack = 1'b1; tbl_rdata = 32'h1234_5678; instr_ready = 1'b1; flush = 1'b1; result = 32'h300;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("err%0d_req", i),   {31'b0, imem_req},    32'h0);
            chk($sformatf("err%0d_valid", i), {31'b0, instr_valid}, 32'h0);
            chk($sformatf("err%0d_err", i),   {31'b0, bus_err},     32'h1);
        end
        tbl_ack = 1'b0; instr_ready = 1'b0; flush = 1'b0; result = '0;
        rst = 1'b0;
        #1;
        chk("err_rst_err", {31'b0, bus_err}, 32'h0);
        chk("err_rst_pc",  pc,               32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Misaligned redirect
        mem_wait = 0; mem_en = 1'b1;
        wait_valid(20, "mis_first");
        chk("mis_first_pc", pc, 32'h0);
        instr_ready = 1'b1; pc_src = 1'b1; result = 32'h102;
        step();
        instr_ready = 1'b0; pc_src = 1'b0; result = '0;
        chk("mis_err",  {31'b0, bus_err},  32'h1);
        chk("mis_addr", imem_addr,         32'h100);
        chk("mis_req",  {31'b0, imem_req}, 32'h1);
        wait_valid(20, "mis_valid");
        chk("mis_pc",    pc,               32'h100);
        chk("mis_instr", instr,            ~32'h100);
        chk("mis_stick", {31'b0, bus_err}, 32'h1);

        // Reset mid-REQ, ack in first cycle after release
        mem_en = 1'b0; tbl_ack = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("mr_addr", imem_addr, 32'h104);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("mr_req",   {31'b0, imem_req},    32'h0);
        chk("mr_pc",    pc,                   32'h0);
        chk("mr_valid", {31'b0, instr_valid}, 32'h0);
        chk("mr_err",   {31'b0, bus_err},     32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        tbl_ack = 1'b1; tbl_rdata = 32'hDEAD_BEEF;
        step();
        tbl_ack = 1'b0;
        chk("mr_ign_valid", {31'b0, instr_valid}, 32'h0);
        chk("mr_ign_req",   {31'b0, imem_req},    32'h1);
        chk("mr_ign_addr",  imem_addr,            32'h0);
        chk("mr_ign_pc",    pc,                   32'h0);
        step();
        chk("mr_ign2_valid", {31'b0, instr_valid}, 32'h0);
        p = instr;
        chk("mr_ign_instr", p, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the ARMv4 core.
- Owns the program counter and runs a request/acknowledge handshake with instruction memory, which may insert wait states.
- Holds one fetched instruction stable for the downstream control unit/decoder until that stage consumes it.
- Applies the PCSrc/Result redirect produced by the execute path; also supplies PC+8 for R15 reads.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ACK_TIMEOUT, 16, max cycles to wait for imem_ack before flagging a bus error (2..255).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- imem_req  output  1  fetch request, held high until imem_ack.
- imem_addr  output  32  fetch address, word aligned, stable while imem_req=1.
- imem_rdata  input  32  instruction word, valid only when imem_ack=1.
- imem_ack  input  1  one-cycle completion strobe.
- instr  output  32  held instruction, feeds the control unit Instr[31:12] and the datapath.
- instr_valid  output  1  instr is valid and not yet consumed.
- instr_ready  input  1  consumer retires the held instruction this cycle.
- pc_src  input  1  redirect select, sampled only on a consume cycle.
- result  input  32  redirect target.
- flush  input  1  abort the outstanding fetch and restart at result.
- pc  output  32  address of the held instruction.
- pc_plus8  output  32  pc + 8, used as the R15 read value.
- bus_err  output  1  sticky; set on a timeout or a misaligned redirect.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, imem_addr=RESET_PC.
  - imem_req=0, instr=0, instr_valid=0, bus_err=0, timeout counter=0, state=IDLE.
  - If reset asserts mid-request, the request is dropped immediately; any ack in the first cycle after release is ignored.
- States: IDLE, REQ, HOLD, DISCARD, ERR.
- IDLE: entered from reset; next cycle -> REQ with imem_req=1, imem_addr=pc.
- REQ:
  - imem_req=1 throughout; the counter increments each cycle without an ack.
  - imem_ack=1 -> instr<=imem_rdata, instr_valid<=1, imem_req<=0, counter<=0, -> HOLD. Fetch latency is one cycle after ack.
  - Counter reaches ACK_TIMEOUT -> bus_err<=1, imem_req<=0, -> ERR.
- HOLD:
  - instr, pc and instr_valid are held until instr_ready=1.
  - On a consume cycle: next pc = pc_src ? result : pc+4; instr_valid<=0; imem_addr<=next pc; imem_req<=1; -> REQ.
  - Minimum issue rate is one instruction every 2 cycles plus memory wait states.
- Redirect alignment: result[1:0]!=0 -> bus_err<=1; the target is used with bits [1:0] forced to 00.
- Flush:
  - flush=1 in HOLD: instr_valid<=0, pc<=result, re-request -> REQ. Flush has priority over instr_ready.
  - flush=1 in REQ with no ack that cycle: record the new pc, -> DISCARD.
  - flush=1 in REQ together with ack: the data is dropped, re-request at result -> REQ.
- DISCARD: imem_req stays high, because the address change is deferred until the outstanding ack. On ack the data is dropped, imem_req drops for one cycle, then -> REQ at the new pc.
- ERR: terminal; imem_req=0, instr_valid=0. Only reset exits.
- Arithmetic:
  - pc+4 and pc+8 are computed mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
  - pc_plus8 is combinational from pc.
- Stability: imem_addr never changes while imem_req=1 and no ack has been received.

Decomposition:
- Shared package core_pkg: fetch_state_t enum (IDLE, REQ, HOLD, DISCARD, ERR), WORD_W=32, PC_STEP=4, PC_R15_OFFSET=8.
- One sub-module: fetch_timeout_ctr, a saturating counter with clear and a terminal flag.
- PC/next-PC muxing and the FSM stay in fetch_stage.

Test Plan:
- Reset, zero-wait memory (ack one cycle after req), instr_ready tied 1 -> imem_addr sequence 0,4,8,C; instr_valid pulses every 2 cycles; pc_plus8=pc+8.
- 3-wait-state memory, instr_ready held 0 for 5 cycles after valid -> instr and pc stable, imem_req=0 throughout the hold, exactly one fetch per instruction.
- In HOLD at pc=0x10: pc_src=1, result=0x100, instr_ready=1 -> next imem_addr=0x100; pc=0x100 when valid.
- flush with result=0x200 two cycles into a pending fetch at 0x20 -> imem_req stays high to ack, data dropped, next request at 0x200, instr_valid never rises for 0x20.
- No ack for ACK_TIMEOUT=16 cycles -> bus_err=1 on cycle 16, imem_req=0, state stays ERR until rst=0; a redirect to 0x102 sets bus_err and fetches 0x100.
- rst deasserted then asserted mid-REQ, with ack arriving the cycle after release -> ack ignored, pc=RESET_PC, instr_valid=0.
